key_counter_multi: RTL and testbench

Parametrised multi-key front end for the 7-segment counter demos: debounces N_KEYS active-low push-buttons and reports a stable level plus press/release pulses per key. Keys held down auto-repeat. Drives a DIGITS-digit packed-BCD up/down/clear counter whose output feeds seg_decoder/seg_scan directly. Replaces the single-key, count-up-only, mod-10 debounce-and-count arrangement.

---
 rtl/key_counter_multi.sv | 196 +++++++++++++++++++
 tb/tb_key_counter_multi.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_counter_multi.sv
`default_nettype none
// key_counter_multi: debounced N-key front end with press/release/auto-repeat pulses
// driving a packed-BCD up/down/clear counter.  Rev 1.0
module key_counter_multi #(
   parameter int N_KEYS          = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int DIGITS          = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_KEYS-1:0]     key_in,
   output logic [N_KEYS-1:0]     key_state,
   output logic [N_KEYS-1:0]     key_press,
   output logic [N_KEYS-1:0]     key_release,
   output logic [N_KEYS-1:0]     key_repeat,
   output logic [4*DIGITS-1:0]   cnt_bcd,
   output logic                  wrap
);

   localparam int DBW   = $clog2(DEBOUNCE_CYCLES);
   localparam int T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW    = $clog2(T_MAX);

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_HOLD   = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      logic           sync1_q;
      logic           sync2_q;
      logic           level_q;      // accepted raw level, 1 = released
      logic [DBW-1:0] db_cnt_q;
      logic           state_q;
      logic           press_q;
      logic           release_q;
      logic           repeat_q;
      rpt_state_e     rpt_q;
      logic [TW-1:0]  tmr_q;
      logic           flip;

      // The synchronised level has disagreed for DEBOUNCE_CYCLES consecutive samples.
      assign flip = (sync2_q != level_q) && (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_q   <= 1'b1;
            db_cnt_q  <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            rpt_q     <= RPT_IDLE;
            tmr_q     <= '0;
         end else begin
            sync1_q   <= key_in[k];
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;

            if (sync2_q == level_q) begin
               db_cnt_q <= '0;
            end else if (flip) begin
               db_cnt_q  <= '0;
               level_q   <= sync2_q;
               state_q   <= ~sync2_q;
               press_q   <= ~sync2_q;
               release_q <= sync2_q;
            end else begin
               db_cnt_q <= db_cnt_q + DBW'(1);
            end

            if (flip && sync2_q) begin
               rpt_q <= RPT_IDLE;
               tmr_q <= '0;
            end else if (flip && !sync2_q) begin
               rpt_q <= RPT_HOLD;
               tmr_q <= '0;
            end else begin
               case (rpt_q)
                  RPT_IDLE: begin
                     tmr_q <= '0;
                  end
                  RPT_HOLD: begin
                     if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
                        repeat_q <= 1'b1;
                        tmr_q    <= '0;
                        rpt_q    <= RPT_REPEAT;
                     end else begin
                        tmr_q <= tmr_q + TW'(1);
                     end
                  end
                  RPT_REPEAT: begin
                     if (tmr_q == TW'(REPEAT_CYCLES - 1)) begin
                        repeat_q <= 1'b1;
                        tmr_q    <= '0;
                     end else begin
                        tmr_q <= tmr_q + TW'(1);
                     end
                  end
                  default: begin
                     rpt_q <= RPT_IDLE;
                     tmr_q <= '0;
                  end
               endcase
            end
         end
      end

      assign key_state[k]   = state_q;
      assign key_press[k]   = press_q;
      assign key_release[k] = release_q;
      assign key_repeat[k]  = repeat_q;
   end

   logic                cnt_up;
   logic                cnt_dn;
   logic                cnt_clr;
   logic [4*DIGITS-1:0] inc_bcd;
   logic [4*DIGITS-1:0] dec_bcd;
   logic                inc_wrap;
   logic                dec_wrap;
   logic                carry;
   logic                borrow;
   logic [4*DIGITS-1:0] cnt_q;
   logic [4*DIGITS-1:0] cnt_d;
   logic                wrap_q;
   logic                wrap_d;

   assign cnt_up  = key_press[0] | key_repeat[0];
   assign cnt_dn  = key_press[1] | key_repeat[1];
   assign cnt_clr = key_press[2];

   // Digit-serial carry/borrow ripple keeps every nibble in 0..9 without a binary detour.
   always_comb begin
      inc_bcd = cnt_q;
      dec_bcd = cnt_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (cnt_q[4*i +: 4] == 4'd9) begin
               inc_bcd[4*i +: 4] = 4'd0;
            end else begin
               inc_bcd[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
         if (borrow) begin
            if (cnt_q[4*i +: 4] == 4'd0) begin
               dec_bcd[4*i +: 4] = 4'd9;
            end else begin
               dec_bcd[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
      inc_wrap = carry;
      dec_wrap = borrow;
   end

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (cnt_up && !cnt_dn) begin
         cnt_d  = inc_bcd;
         wrap_d = inc_wrap;
      end else if (cnt_dn && !cnt_up) begin
         cnt_d  = dec_bcd;
         wrap_d = dec_wrap;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt_bcd = cnt_q;
   assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_key_counter_multi.sv
`default_nettype none
// tb_key_counter_multi: drives key_counter_multi with directed and random key activity
// and compares every cycle against an event-level reference model.
module tb_key_counter_multi;

   localparam int NK  = 4;
   localparam int DB  = 4;
   localparam int HC  = 20;
   localparam int RC  = 5;
   localparam int DG  = 2;
   localparam int MOD = 100;

   logic            clk;
   logic            rst;
   logic [NK-1:0]   key_in;
   logic [NK-1:0]   key_state;
   logic [NK-1:0]   key_press;
   logic [NK-1:0]   key_release;
   logic [NK-1:0]   key_repeat;
   logic [4*DG-1:0] cnt_bcd;
   logic            wrap;
   logic [24:0]     dut_vec;

   int n_chk;
   int n_pass;

   key_counter_multi #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC),
      .REPEAT_CYCLES(RC), .DIGITS(DG)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in),
      .key_state(key_state), .key_press(key_press), .key_release(key_release),
      .key_repeat(key_repeat), .cnt_bcd(cnt_bcd), .wrap(wrap)
   );

   assign dut_vec = {key_state, key_press, key_release, key_repeat, cnt_bcd, wrap};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit pipe [NK][$];
   bit win  [NK][$];
   bit m_acc [NK];
   bit m_st  [NK];
   bit m_pr  [NK];
   bit m_rl  [NK];
   bit m_rp  [NK];
   bit m_hold[NK];
   int m_age [NK];
   int m_val;
   bit m_wrap;

   function automatic void model_reset();
      for (int k = 0; k < NK; k++) begin
         pipe[k] = {1'b1, 1'b1};
         win[k].delete();
         m_acc[k] = 1'b1; m_st[k] = 0; m_pr[k] = 0; m_rl[k] = 0; m_rp[k] = 0;
         m_hold[k] = 0; m_age[k] = 0;
      end
      m_val  = 0;
      m_wrap = 0;
   endfunction

   function automatic void model_step();
      bit up, dn, clr, s, flip;
      up  = m_pr[0] | m_rp[0];
      dn  = m_pr[1] | m_rp[1];
      clr = m_pr[2];
      m_wrap = 0;
      if (clr) m_val = 0;
      else if (up && dn) m_val = m_val;
      else if (up) begin
         if (m_val == MOD - 1) begin m_val = 0; m_wrap = 1; end
         else m_val = m_val + 1;
      end else if (dn) begin
         if (m_val == 0) begin m_val = MOD - 1; m_wrap = 1; end
         else m_val = m_val - 1;
      end
      for (int k = 0; k < NK; k++) begin
         s = pipe[k].pop_front();
         pipe[k].push_back(key_in[k]);
         win[k].push_back(s);
         if (win[k].size() > DB) void'(win[k].pop_front());
         m_pr[k] = 0; m_rl[k] = 0; m_rp[k] = 0;
         flip = (win[k].size() == DB);
         for (int i = 0; i < win[k].size(); i++)
            if (win[k][i] == m_acc[k]) flip = 0;
         if (flip) begin
            m_acc[k]  = s;
            m_st[k]   = !s;
            m_pr[k]   = !s;
            m_rl[k]   = s;
            m_hold[k] = !s;
            m_age[k]  = 0;
         end else if (m_hold[k]) begin
            m_age[k] = m_age[k] + 1;
            if (m_age[k] == HC || (m_age[k] > HC && (m_age[k] - HC) % RC == 0)) m_rp[k] = 1;
         end
      end
   endfunction

   function automatic logic [24:0] mdl_vec();
      logic [NK-1:0] st, pr, rl, rp;
      logic [7:0]    bcd;
      for (int k = 0; k < NK; k++) begin
         st[k] = m_st[k]; pr[k] = m_pr[k]; rl[k] = m_rl[k]; rp[k] = m_rp[k];
      end
      bcd = {4'(m_val / 10), 4'(m_val % 10)};
      return {st, pr, rl, rp, bcd, m_wrap};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      n_chk++;
      if (dut_vec !== 25'h0) $display("FAIL reset_values got=%h exp=%h", dut_vec, 25'h0);
      else n_pass++;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL reset_release t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
      end
   endtask

   task automatic test_clean_press();
      int press_at = -1, rel_at = -1, reps = 0;
      logic [7:0] cnt_at7 = 8'hxx;
      key_in[0] = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL clean_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
         if (key_press[0] && press_at < 0) press_at = c;
         if (key_repeat[0]) reps++;
         if (c == 7) cnt_at7 = cnt_bcd;
      end
      key_in[0] = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL clean_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
         if (key_release[0] && rel_at < 0) rel_at = c;
         if (key_repeat[0]) reps++;
      end
      n_chk++;
      if (press_at !== 6) $display("FAIL clean_press_latency got=%0d exp=6", press_at); else n_pass++;
      n_chk++;
      if (cnt_at7 !== 8'h01) $display("FAIL clean_count got=%h exp=01", cnt_at7); else n_pass++;
      n_chk++;
      if (rel_at !== 6) $display("FAIL clean_release_latency got=%0d exp=6", rel_at); else n_pass++;
      n_chk++;
      if (reps !== 0) $display("FAIL clean_no_repeat got=%0d exp=0", reps); else n_pass++;
   endtask

   task automatic test_bounce();
      int st_seen = 0;
      for (int b = 0; b < 20; b++) begin
         key_in[0] = b[0];
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec()) $display("FAIL bounce_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
            else n_pass++;
            if (key_state[0]) st_seen++;
         end
      end
      key_in[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (key_state[0]) st_seen++;
      end
      n_chk++;
      if (st_seen !== 0) $display("FAIL bounce_state got=%0d exp=0", st_seen); else n_pass++;
      n_chk++;
      if (cnt_bcd !== 8'h01) $display("FAIL bounce_count got=%h exp=01", cnt_bcd); else n_pass++;
   endtask

   task automatic test_hold();
      int reps = 0;
      logic [7:0] cnt_end = 8'hxx;
      key_in[2] = 1'b0;
      repeat (8) @(negedge clk);
      key_in[2] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL hold_clear_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
      end
      key_in[0] = 1'b0;
      for (int c = 1; c <= 57; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL hold_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
         if (key_repeat[0]) reps++;
         if (c == 57) cnt_end = cnt_bcd;
      end
      key_in[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL hold_release_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
      end
      n_chk++;
      if (reps !== 7) $display("FAIL hold_repeat_count got=%0d exp=7", reps); else n_pass++;
      n_chk++;
      if (cnt_end !== 8'h08) $display("FAIL hold_count got=%h exp=08", cnt_end); else n_pass++;
   endtask

   // One press/release of the keys in msk, 16 cycles, model-checked each cycle.
   task automatic test_wrap();
      int wraps;
      logic [NK-1:0] msk;
      for (int p = 0; p < 102; p++) begin
         msk = (p == 0) ? 4'b0100 : (p == 101) ? 4'b0010 : 4'b0001;
         wraps = 0;
         for (int c = 0; c < 16; c++) begin
            key_in = (c < 8) ? ~msk : '1;
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec()) $display("FAIL wrap_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
            else n_pass++;
            if (wrap) wraps++;
         end
         if (p == 0) begin
            n_chk++;
            if (cnt_bcd !== 8'h00) $display("FAIL wrap_clear got=%h exp=00", cnt_bcd); else n_pass++;
         end
         if (p == 99) begin
            n_chk++;
            if (cnt_bcd !== 8'h99) $display("FAIL wrap_preload got=%h exp=99", cnt_bcd); else n_pass++;
         end
         if (p == 100) begin
            n_chk++;
            if (cnt_bcd !== 8'h00 || wraps !== 1) $display("FAIL wrap_up got=%h/%0d exp=00/1", cnt_bcd, wraps); else n_pass++;
         end
         if (p == 101) begin
            n_chk++;
            if (cnt_bcd !== 8'h99 || wraps !== 1) $display("FAIL wrap_down got=%h/%0d exp=99/1", cnt_bcd, wraps); else n_pass++;
         end
      end
   endtask

   task automatic test_simultaneous();
      int wraps;
      logic [NK-1:0] msk;
      for (int p = 0; p < 40; p++) begin
         msk = (p == 0) ? 4'b0011 : (p == 1) ? 4'b0100 : (p == 39) ? 4'b0101 : 4'b0001;
         wraps = 0;
         for (int c = 0; c < 16; c++) begin
            key_in = (c < 8) ? ~msk : '1;
            @(negedge clk);
            n_chk++;
            if (dut_vec !== mdl_vec()) $display("FAIL simul_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
            else n_pass++;
            if (wrap) wraps++;
         end
         if (p == 0) begin
            n_chk++;
            if (cnt_bcd !== 8'h99) $display("FAIL simul_updown got=%h exp=99", cnt_bcd); else n_pass++;
         end
         if (p == 38) begin
            n_chk++;
            if (cnt_bcd !== 8'h37) $display("FAIL simul_preload got=%h exp=37", cnt_bcd); else n_pass++;
         end
         if (p == 39) begin
            n_chk++;
            if (cnt_bcd !== 8'h00 || wraps !== 0) $display("FAIL simul_upclear got=%h/%0d exp=00/0", cnt_bcd, wraps); else n_pass++;
         end
      end
   endtask

   task automatic test_async_reset();
      int press_at = -1, presses = 0;
      key_in[0] = 1'b0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL areset_pre_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
      end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (dut_vec !== 25'h0) $display("FAIL areset_immediate got=%h exp=%h", dut_vec, 25'h0); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL areset_post_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
         if (key_press[0]) begin
            presses++;
            if (press_at < 0) press_at = c;
         end
      end
      n_chk++;
      if (press_at !== DB + 2 || presses !== 1)
         $display("FAIL areset_repress got=%0d/%0d exp=%0d/1", press_at, presses, DB + 2);
      else n_pass++;
      key_in = '1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_random();
      int seg[NK];
      for (int k = 0; k < NK; k++) seg[k] = $urandom_range(1, 10);
      for (int c = 0; c < 2000; c++) begin
         for (int k = 0; k < NK; k++) begin
            seg[k]--;
            if (seg[k] <= 0) begin
               key_in[k] = ~key_in[k];
               seg[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
            end
         end
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL random_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
      end
      key_in = '1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_chk++;
         if (dut_vec !== mdl_vec()) $display("FAIL random_settle t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec());
         else n_pass++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      n_chk  = 0;
      n_pass = 0;
      key_in = '1;
      rst    = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_hold();
      test_wrap();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
